// File: rtl/vdp_vram_arbiter.sv
// Shares the single VDP VRAM port among screen, sprite, CPU and command requesters.
// One access per cycle, one read in flight, with a read timeout and an initial-busy block.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | may grant one requester per cycle (writes run back-to-back)
// S_RD_WAIT | one read outstanding; no grants until data or timeout
module vdp_vram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 initial_busy,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*17-1:0]   req_address,
    input  logic [NREQ*8-1:0]    req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          req_rdata,
    output logic [NREQ-1:0]      req_rdata_en,
    output logic [16:0]          vram_address,
    output logic                 vram_write,
    output logic                 vram_valid,
    output logic [7:0]           vram_wdata,
    input  logic [31:0]          vram_rdata,
    input  logic                 vram_rdata_en,
    output logic                 timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            rr_q, rr_d;
    logic            vram_valid_q, vram_valid_d;
    logic [16:0]     vram_address_q, vram_address_d;
    logic            vram_write_q, vram_write_d;
    logic [7:0]      vram_wdata_q, vram_wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [NREQ-1:0] rdata_en_q, rdata_en_d;
    logic            terr_q, terr_d;

    logic [16:0]     addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];
    logic            grant_vld;
    logic [1:0]      grant_idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_address[i*17 +: 17];
            wdata_arr[i] = req_wdata[i*8 +: 8];
        end
    end

    // Fixed priority 0 > 1, then 2/3 share by round-robin (rr_q=0 tries 2 first).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        if (reset_n && state_q == S_IDLE && !initial_busy) begin
            grant_vld = 1'b1;
            if (req_valid[0]) begin
                grant_idx = 2'd0;
            end else if (req_valid[1]) begin
                grant_idx = 2'd1;
            end else if (req_valid[2] && req_valid[3]) begin
                grant_idx = rr_q ? 2'd3 : 2'd2;
            end else if (req_valid[2]) begin
                grant_idx = 2'd2;
            end else if (req_valid[3]) begin
                grant_idx = 2'd3;
            end else begin
                grant_vld = 1'b0;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        timer_d        = timer_q;
        rr_d           = rr_q;
        vram_valid_d   = 1'b0;
        vram_address_d = vram_address_q;
        vram_write_d   = vram_write_q;
        vram_wdata_d   = vram_wdata_q;
        rdata_d        = rdata_q;
        rdata_en_d     = '0;
        terr_d         = terr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    vram_valid_d   = 1'b1;
                    vram_address_d = addr_arr[grant_idx];
                    vram_write_d   = req_write[grant_idx];
                    vram_wdata_d   = wdata_arr[grant_idx];
                    if (grant_idx[1]) begin
                        rr_d = ~grant_idx[0];
                    end
                    if (!req_write[grant_idx]) begin
                        owner_d = grant_idx;
                        timer_d = TW'(TIMEOUT - 1);
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                // Real data wins over a timeout landing in the same cycle.
                if (vram_rdata_en) begin
                    rdata_d             = vram_rdata;
                    rdata_en_d[owner_q] = 1'b1;
                    state_d             = S_IDLE;
                end else if (timer_q == '0) begin
                    rdata_d             = '0;
                    rdata_en_d[owner_q] = 1'b1;
                    terr_d              = 1'b1;
                    state_d             = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            owner_q        <= 2'd0;
            timer_q        <= '0;
            rr_q           <= 1'b0;
            vram_valid_q   <= 1'b0;
            vram_address_q <= '0;
            vram_write_q   <= 1'b0;
            vram_wdata_q   <= '0;
            rdata_q        <= '0;
            rdata_en_q     <= '0;
            terr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            timer_q        <= timer_d;
            rr_q           <= rr_d;
            vram_valid_q   <= vram_valid_d;
            vram_address_q <= vram_address_d;
            vram_write_q   <= vram_write_d;
            vram_wdata_q   <= vram_wdata_d;
            rdata_q        <= rdata_d;
            rdata_en_q     <= rdata_en_d;
            terr_q         <= terr_d;
        end
    end

    assign vram_valid   = vram_valid_q;
    assign vram_address = vram_address_q;
    assign vram_write   = vram_write_q;
    assign vram_wdata   = vram_wdata_q;
    assign req_rdata    = rdata_q;
    assign req_rdata_en = rdata_en_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: request queues, a VRAM responder with programmable
// latency, a transaction-level reference model checked every cycle, plus directed scenarios.
module tb_vdp_vram_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        initial_busy;
    logic [3:0]  req_valid;
    logic [3:0]  req_write;
    logic [67:0] req_address;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [31:0] req_rdata;
    logic [3:0]  req_rdata_en;
    logic [16:0] vram_address;
    logic        vram_write;
    logic        vram_valid;
    logic [7:0]  vram_wdata;
    logic [31:0] vram_rdata;
    logic        vram_rdata_en;
    logic        timeout_err;

    vdp_vram_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .initial_busy (initial_busy),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .req_rdata    (req_rdata),
        .req_rdata_en (req_rdata_en),
        .vram_address (vram_address),
        .vram_write   (vram_write),
        .vram_valid   (vram_valid),
        .vram_wdata   (vram_wdata),
        .vram_rdata   (vram_rdata),
        .vram_rdata_en(vram_rdata_en),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] pat(int w);
        return 32'hC3000000 ^ (w * 32'h00000101);
    endfunction

    // ---------------- VRAM memory and responder ----------------
    logic [31:0] mem [0:32767];
    int          rsp_delay;
    int          rsp_cyc [$];
    logic [31:0] rsp_dat [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (vram_valid) begin
            if (vram_write)
                mem[vram_address[16:2]][vram_address[1:0]*8 +: 8] = vram_wdata;
            else if (rsp_delay >= 0) begin
                rsp_cyc.push_back(cyc + rsp_delay);
                rsp_dat.push_back(mem[vram_address[16:2]]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        while (rsp_cyc.size() > 0 && rsp_cyc[0] < cyc) begin
            void'(rsp_cyc.pop_front());
            void'(rsp_dat.pop_front());
        end
        if (rsp_cyc.size() > 0 && rsp_cyc[0] == cyc) begin
            vram_rdata_en = 1'b1;
            vram_rdata    = rsp_dat[0];
            void'(rsp_cyc.pop_front());
            void'(rsp_dat.pop_front());
        end else begin
            vram_rdata_en = 1'b0;
            vram_rdata    = 32'h0BAD0BAD ^ cyc;
        end
    end

    // ---------------- requester queues: {write, addr[16:0], wdata[7:0]} ----------------
    logic [25:0] rq [4][$];
    logic [3:0]  accepted = 4'b0;
    logic [25:0] drv_ent;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (accepted[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            accepted[i] = 1'b0;
            if (rq[i].size() > 0) begin
                drv_ent              = rq[i][0];
                req_valid[i]         = 1'b1;
                req_write[i]         = drv_ent[25];
                req_address[i*17 +: 17] = drv_ent[24:8];
                req_wdata[i*8 +: 8]  = drv_ent[7:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    task automatic push(int i, logic w, logic [16:0] a, logic [7:0] d);
        rq[i].push_back({w, a, d});
    endtask

    // ---------------- event logs ----------------
    int          gl_idx [$];
    int          gl_cyc [$];
    logic [3:0]  rl_vec [$];
    int          rl_cyc [$];
    logic [31:0] rl_dat [$];
    int          vv_cnt = 0;

    task automatic clear_logs();
        gl_idx.delete(); gl_cyc.delete();
        rl_vec.delete(); rl_cyc.delete(); rl_dat.delete();
        vv_cnt = 0;
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    int          m_waited = 0;
    int          m_rr = 2;
    int          m_g;
    logic [3:0]  m_ready;
    logic        e_valid = 1'b0, e_write = 1'b0, e_terr = 1'b0;
    logic [16:0] e_addr = '0;
    logic [7:0]  e_wdata = '0;
    logic [31:0] e_rdata = '0;
    logic [3:0]  e_rden = '0;

    function automatic int pick(logic [3:0] v, int rr);
        if (v[0]) return 0;
        if (v[1]) return 1;
        if (v[2] && v[3]) return rr;
        if (v[2]) return 2;
        if (v[3]) return 3;
        return -1;
    endfunction

    always @(negedge clk) begin
        m_g     = pick(req_valid, m_rr);
        m_ready = 4'b0;
        if (reset_n && !m_busy && !initial_busy && m_g >= 0) m_ready[m_g] = 1'b1;

        if (chk_en) begin
            check("req_ready",    req_ready,    m_ready);
            check("vram_valid",   vram_valid,   e_valid);
            check("vram_address", vram_address, e_addr);
            check("vram_write",   vram_write,   e_write);
            check("vram_wdata",   vram_wdata,   e_wdata);
            check("req_rdata",    req_rdata,    e_rdata);
            check("req_rdata_en", req_rdata_en, e_rden);
            check("timeout_err",  timeout_err,  e_terr);
        end

        if (req_ready != 4'b0) begin
            for (int i = 0; i < 4; i++) if (req_ready[i]) begin
                gl_idx.push_back(i);
                gl_cyc.push_back(cyc);
            end
            accepted = accepted | req_ready;
        end
        if (req_rdata_en != 4'b0) begin
            rl_vec.push_back(req_rdata_en);
            rl_cyc.push_back(cyc);
            rl_dat.push_back(req_rdata);
        end
        if (vram_valid) vv_cnt++;

        if (!reset_n) begin
            m_busy = 1'b0; m_rr = 2; m_waited = 0; m_owner = 0;
            e_valid = 1'b0; e_write = 1'b0; e_terr = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_rden = '0;
        end else begin
            e_valid = 1'b0;
            e_rden  = 4'b0;
            if (m_busy) begin
                m_waited++;
                if (vram_rdata_en) begin
                    e_rdata = vram_rdata;
                    e_rden[m_owner] = 1'b1;
                    m_busy = 1'b0;
                end else if (m_waited == TIMEOUT) begin
                    e_rdata = 32'h0;
                    e_rden[m_owner] = 1'b1;
                    e_terr = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (m_ready != 4'b0) begin
                e_valid = 1'b1;
                e_addr  = req_address[m_g*17 +: 17];
                e_write = req_write[m_g];
                e_wdata = req_wdata[m_g*8 +: 8];
                if (m_g >= 2) m_rr = (m_g == 2) ? 3 : 2;
                if (!req_write[m_g]) begin
                    m_busy = 1'b1; m_owner = m_g; m_waited = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #2;
    endtask

    function automatic bit all_quiet();
        return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
               rq[3].size() == 0 && !m_busy && rsp_cyc.size() == 0 && accepted == 4'b0;
    endfunction

    task automatic wait_idle(int budget, string name);
        int n;
        n = 0;
        while (!all_quiet() && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (!all_quiet()) begin
            n_checks++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; initial_busy = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
        vram_rdata = '0; vram_rdata_en = 1'b0; rsp_delay = 2;
        for (int i = 0; i < 32768; i++) mem[i] = pat(i);
        mem[15'h0040] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #2;

        // 1: initial_busy holds everything off
        clear_logs();
        initial_busy = 1'b1;
        push(0, 1'b0, 17'h00000, 8'h00);
        push(1, 1'b0, 17'h00004, 8'h00);
        push(2, 1'b0, 17'h00008, 8'h00);
        push(3, 1'b0, 17'h0000C, 8'h00);
        repeat (1000) @(posedge clk);
        #2;
        check("t1_no_vram_valid", vv_cnt, 0);
        check("t1_no_ready", gl_idx.size(), 0);
        initial_busy = 1'b0;
        wait_idle(200, "t1_release");
        check("t1_grants", gl_idx.size(), 4);
        if (gl_idx.size() == 4) begin
            check("t1_order0", gl_idx[0], 0);
            check("t1_order1", gl_idx[1], 1);
            check("t1_order2", gl_idx[2], 2);
            check("t1_order3", gl_idx[3], 3);
        end
        if (rl_dat.size() == 4) check("t1_rdata3", rl_dat[3], pat(3));

        // 2: screen read beats simultaneous cpu write
        do_reset();
        clear_logs();
        rsp_delay = 2;
        push(0, 1'b0, 17'h00100, 8'h00);
        push(2, 1'b1, 17'h1FFFF, 8'hA5);
        wait_idle(100, "t2");
        check("t2_grants", gl_idx.size(), 2);
        check("t2_rdone", rl_vec.size(), 1);
        if (gl_idx.size() == 2 && rl_vec.size() == 1) begin
            check("t2_first", gl_idx[0], 0);
            check("t2_second", gl_idx[1], 2);
            check("t2_rden_vec", rl_vec[0], 4'b0001);
            check("t2_rdata", rl_dat[0], 32'hDEADBEEF);
            check("t2_rden_lat", rl_cyc[0] - gl_cyc[0], 4);
            check("t2_cpu_after", gl_cyc[1] - gl_cyc[0], 4);
        end
        check("t2_mem_byte", mem[15'h7FFF][31:24], 8'hA5);

        // 3: cpu and command writes alternate back-to-back
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            push(2, 1'b1, 17'h00200 + 17'(k), 8'h10 + 8'(k));
            push(3, 1'b1, 17'h00300 + 17'(k), 8'h20 + 8'(k));
        end
        wait_idle(100, "t3");
        check("t3_grants", gl_idx.size(), 8);
        check("t3_vv_cnt", vv_cnt, 8);
        if (gl_idx.size() == 8)
            for (int k = 0; k < 8; k++) begin
                check("t3_alt", gl_idx[k], (k % 2 == 0) ? 2 : 3);
                check("t3_consec", gl_cyc[k] - gl_cyc[0], k);
            end
        check("t3_mem_cpu", mem[15'h0080], 32'h13121110);
        check("t3_mem_cmd", mem[15'h00C0], 32'h23222120);

        // 4: read latency with VRAM delay 3, competing write held off
        do_reset();
        clear_logs();
        rsp_delay = 3;
        push(0, 1'b0, 17'h00044, 8'h00);
        push(2, 1'b1, 17'h00050, 8'h3C);
        wait_idle(100, "t4");
        check("t4_rdone", rl_vec.size(), 1);
        check("t4_grants", gl_idx.size(), 2);
        if (rl_vec.size() == 1 && gl_idx.size() == 2) begin
            check("t4_lat", rl_cyc[0] - gl_cyc[0], 5);
            check("t4_owner", rl_vec[0], 4'b0001);
            check("t4_rdata", rl_dat[0], pat(32'h11));
            check("t4_next_idx", gl_idx[1], 2);
            check("t4_next_gap", gl_cyc[1] - gl_cyc[0], 5);
        end

        // 5: VRAM never answers -> timeout, then service resumes
        do_reset();
        clear_logs();
        rsp_delay = -1;
        push(1, 1'b0, 17'h00010, 8'h00);
        push(2, 1'b1, 17'h00020, 8'h77);
        wait_idle(300, "t5");
        check("t5_rdone", rl_vec.size(), 1);
        check("t5_grants", gl_idx.size(), 2);
        if (rl_vec.size() == 1 && gl_idx.size() == 2) begin
            check("t5_first", gl_idx[0], 1);
            check("t5_lat", rl_cyc[0] - gl_cyc[0], TIMEOUT + 1);
            check("t5_owner", rl_vec[0], 4'b0010);
            check("t5_rdata", rl_dat[0], 32'h0);
            check("t5_next_idx", gl_idx[1], 2);
            check("t5_next_gap", gl_cyc[1] - gl_cyc[0], TIMEOUT + 1);
        end
        check("t5_terr", timeout_err, 1'b1);
        rsp_delay = 2;
        push(2, 1'b0, 17'h00008, 8'h00);
        wait_idle(100, "t5_after");
        if (rl_dat.size() == 2) check("t5_after_rdata", rl_dat[1], pat(2));
        check("t5_terr_sticky", timeout_err, 1'b1);

        // 6: reset during a read, late response must be dropped
        do_reset();
        clear_logs();
        rsp_delay = 5;
        push(3, 1'b0, 17'h00400, 8'h00);
        n = 0;
        while (gl_idx.size() == 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("t6_granted", gl_idx.size(), 1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("t6_no_rden", rl_vec.size(), 0);
        check("t6_rdata_en", req_rdata_en, 4'b0);
        check("t6_rdata", req_rdata, 32'h0);
        check("t6_ready", req_ready, 4'b0);
        check("t6_vvalid", vram_valid, 1'b0);
        check("t6_vaddr", vram_address, 17'h0);
        check("t6_terr", timeout_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
